// File: rtl/pet_loader_pkg.sv
// pet_loader_pkg: states and constants shared by the PET PRG/ROM download loader.
// Optional feature macro: PET_LOADER_AUTORUN_EN (adds the AUTORUN state and its constants).
package pet_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_ROM,
    ST_PATCH,
`ifdef PET_LOADER_AUTORUN_EN
    ST_AUTORUN,
`endif
    ST_DONE
  } loader_state_t;

  localparam logic [7:0]  PRG_INDEX_DEFAULT = 8'h41;
  localparam logic [7:0]  ROM_INDEX_DEFAULT = 8'h00;
  localparam logic [15:0] RAM_TOP_DEFAULT   = 16'h8000;
  localparam logic [15:0] PTR_BASE_DEFAULT  = 16'h002A;

  // VARTAB, ARYTAB and STREND sit at offsets 0, 2 and 4; each is a lo/hi pair,
  // so the last patch write lands at STREND high byte.
  localparam int          STREND_OFS = 4;
  localparam logic [2:0]  PATCH_LAST = 3'(STREND_OFS + 1);

  // ROM image window in file offsets, moved up by 0x8000 into the ROM area.
  localparam logic [24:0] ROM_WIN_LO = 25'h000_0400;
  localparam logic [24:0] ROM_WIN_HI = 25'h000_8000;
  localparam logic [15:0] ROM_REMAP  = 16'h8000;

`ifdef PET_LOADER_AUTORUN_EN
  localparam logic [15:0] KBD_BUF_ADDR   = 16'h026F;
  localparam logic [15:0] KBD_COUNT_ADDR = 16'h009E;
  localparam logic [7:0]  KBD_COUNT      = 8'h04;
  localparam logic [2:0]  AUTORUN_LAST   = 3'd4;
  // "RUN\r", element 0 is 'R'.
  localparam logic [3:0][7:0] AUTORUN_BYTES = {8'h0D, 8'h4E, 8'h55, 8'h52};
`endif

  // Even patch slots carry the pointer low byte, odd slots the high byte.
  function automatic logic [7:0] patch_byte(input logic [15:0] ptr, input logic [2:0] slot);
    return slot[0] ? ptr[15:8] : ptr[7:0];
  endfunction

endpackage

// File: rtl/pet_dma_pacer.sv
// pet_dma_pacer: registers one DMA write per request and holds ioctl_wait
// for WR_GAP idle cycles after each write strobe.
module pet_dma_pacer #(
  parameter int WR_GAP = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_we,
  output logic        ioctl_wait,
  output logic        ready
);

  logic [3:0] gap_cnt;

  // A request always wins (last write wins); otherwise the gap counter drains
  // and ioctl_wait stays high until it has reached zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_addr   <= '0;
      dma_dout   <= '0;
      dma_we     <= 1'b0;
      ioctl_wait <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      dma_we <= req;
      if (req) begin
        dma_addr   <= addr;
        dma_dout   <= data;
        ioctl_wait <= 1'b1;
        gap_cnt    <= 4'(WR_GAP);
      end else begin
        ioctl_wait <= (gap_cnt != 4'd0);
        if (gap_cnt != 4'd0)
          gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  assign ready = !ioctl_wait;

endmodule

// File: rtl/pet_prg_loader.sv
// pet_prg_loader: turns the HPS ioctl download stream into paced PET RAM writes.
// PRG files are loaded at their embedded address and the BASIC end pointers are
// patched afterwards; ROM images are remapped into 0x8400..0xFFFF.
// Optional feature macro: PET_LOADER_AUTORUN_EN (types "RUN" into the keyboard buffer).
module pet_prg_loader
  import pet_loader_pkg::*;
#(
  parameter logic [7:0]  PRG_INDEX = PRG_INDEX_DEFAULT,
  parameter logic [7:0]  ROM_INDEX = ROM_INDEX_DEFAULT,
  parameter logic [15:0] RAM_TOP   = RAM_TOP_DEFAULT,
  parameter int          WR_GAP    = 3,
  parameter logic [15:0] PTR_BASE  = PTR_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        overflow
`ifdef PET_LOADER_AUTORUN_EN
  , input  logic      autorun
`endif
);

  loader_state_t state;
  logic [15:0]   ptr;
  logic [2:0]    slot;
  logic          dl_prev;
  logic          ready;
  logic          pace_req;
  logic [15:0]   pace_addr;
  logic [7:0]    pace_data;
`ifdef PET_LOADER_AUTORUN_EN
  logic          autorun_en;
`endif

  wire dl_rise = ioctl_download && !dl_prev;
  wire dl_fall = !ioctl_download && dl_prev;

  // Write requests go straight to the pacer so dma_we follows ioctl_wr by one
  // cycle; a restart edge suppresses any request so an aborted load writes nothing more.
  always_comb begin
    pace_req  = 1'b0;
    pace_addr = ptr;
    pace_data = ioctl_dout;
    if (!dl_rise) begin
      case (state)
        ST_DATA: pace_req = ioctl_wr && (ptr < RAM_TOP);
        ST_ROM: begin
          pace_req  = ioctl_wr && (ioctl_addr >= ROM_WIN_LO) && (ioctl_addr < ROM_WIN_HI);
          pace_addr = ioctl_addr[15:0] + ROM_REMAP;
        end
        ST_PATCH: begin
          pace_req  = ready;
          pace_addr = PTR_BASE + {13'd0, slot};
          pace_data = patch_byte(ptr, slot);
        end
`ifdef PET_LOADER_AUTORUN_EN
        ST_AUTORUN: begin
          pace_req  = ready;
          pace_addr = (slot == AUTORUN_LAST) ? KBD_COUNT_ADDR : KBD_BUF_ADDR + {14'd0, slot[1:0]};
          pace_data = (slot == AUTORUN_LAST) ? KBD_COUNT : AUTORUN_BYTES[slot[1:0]];
        end
`endif
        default: ;
      endcase
    end
  end

  // Loader sequencing: a rising download edge (re)starts per the latched index,
  // the falling edge ends the stream, and patch/autorun writes advance on ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      slot     <= '0;
      dl_prev  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
`ifdef PET_LOADER_AUTORUN_EN
      autorun_en <= 1'b0;
`endif
    end else begin
      dl_prev <= ioctl_download;
      done    <= 1'b0;
      if (dl_rise) begin
        slot <= '0;
`ifdef PET_LOADER_AUTORUN_EN
        autorun_en <= autorun;
`endif
        if (ioctl_index == PRG_INDEX) begin
          state    <= ST_HDR_LO;
          busy     <= 1'b1;
          overflow <= 1'b0;
        end else if (ioctl_index == ROM_INDEX) begin
          state <= ST_ROM;
          busy  <= 1'b1;
        end else begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: ;
          ST_HDR_LO: begin
            if (dl_fall)
              state <= ST_DONE;
            else if (ioctl_wr && ioctl_addr == 25'd0) begin
              ptr[7:0] <= ioctl_dout;
              state    <= ST_HDR_HI;
            end
          end
          ST_HDR_HI: begin
            if (dl_fall)
              state <= ST_DONE;
            else if (ioctl_wr && ioctl_addr == 25'd1) begin
              ptr[15:8] <= ioctl_dout;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (ioctl_wr) begin
              if (ptr < RAM_TOP)
                ptr <= ptr + 16'd1;
              else
                overflow <= 1'b1;
            end
            if (dl_fall)
              state <= ST_PATCH;
          end
          ST_ROM: begin
            if (dl_fall)
              state <= ST_DONE;
          end
          ST_PATCH: begin
            if (ready) begin
              if (slot == PATCH_LAST) begin
                slot <= '0;
`ifdef PET_LOADER_AUTORUN_EN
                state <= autorun_en ? ST_AUTORUN : ST_DONE;
`else
                state <= ST_DONE;
`endif
              end else
                slot <= slot + 3'd1;
            end
          end
`ifdef PET_LOADER_AUTORUN_EN
          ST_AUTORUN: begin
            if (ready) begin
              if (slot == AUTORUN_LAST) begin
                slot  <= '0;
                state <= ST_DONE;
              end else
                slot <= slot + 3'd1;
            end
          end
`endif
          ST_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  pet_dma_pacer #(
    .WR_GAP(WR_GAP)
  ) u_pacer (
    .clk        (clk),
    .reset      (reset),
    .req        (pace_req),
    .addr       (pace_addr),
    .data       (pace_data),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_we     (dma_we),
    .ioctl_wait (ioctl_wait),
    .ready      (ready)
  );

endmodule

// File: tb/tb_pet_prg_loader.sv
// tb_pet_prg_loader: directed bench for the PET PRG/ROM loader.
// Optional feature macro: PET_LOADER_AUTORUN_EN (also exercises the autorun sequence).
module tb_pet_prg_loader;

  logic        clk;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef PET_LOADER_AUTORUN_EN
  logic        autorun;
`endif

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int done_base;
  logic [15:0] wlog_addr[$];
  logic [7:0]  wlog_data[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];

  pet_prg_loader #(
    .PRG_INDEX (8'h41),
    .ROM_INDEX (8'h00),
    .RAM_TOP   (16'h8000),
    .WR_GAP    (3),
    .PTR_BASE  (16'h002A)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dma_addr       (dma_addr),
    .dma_dout       (dma_dout),
    .dma_we         (dma_we),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
`ifdef PET_LOADER_AUTORUN_EN
    , .autorun      (autorun)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every cycle that carries a DMA write strobe, plus done pulses.
  always @(negedge clk) begin
    if (dma_we === 1'b1) begin
      wlog_addr.push_back(dma_addr);
      wlog_data.push_back(dma_dout);
    end
    if (done === 1'b1)
      done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expectWrite(input logic [15:0] a, input logic [7:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic expectPointers(input logic [15:0] p);
    for (int i = 0; i < 3; i++) begin
      expectWrite(16'h002A + 16'(2 * i), p[7:0]);
      expectWrite(16'h002B + 16'(2 * i), p[15:8]);
    end
  endtask

  // Compare the recorded write log with the expected list, then clear both.
  task automatic checkLog(input string tag);
    checkOutput({tag, "_count"}, 32'(wlog_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < wlog_addr.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wlog_addr[i]), 32'(exp_addr[i]));
      checkOutput($sformatf("%s_data%0d", tag, i), 32'(wlog_data[i]), 32'(exp_data[i]));
    end
    wlog_addr.delete();
    wlog_data.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic startDownload(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic endDownload();
    ioctl_download = 1'b0;
    tick();
    repeat (80) tick();
  endtask

  // One ioctl byte; five cycles per byte so the pacing gap is always respected.
  task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d, input logic exp_we, input logic chk_pace);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checkOutput($sformatf("we_at_%0h", a), dma_we, exp_we);
    if (chk_pace) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("wait_hi%0d", i), ioctl_wait, 1'b1);
        tick();
      end
      checkOutput("wait_lo", ioctl_wait, 1'b0);
    end else begin
      repeat (4) tick();
    end
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
`ifdef PET_LOADER_AUTORUN_EN
    autorun        = 1'b0;
`endif
    tick();
    tick();
    checkOutput("rst_wait", ioctl_wait, 1'b0);
    checkOutput("rst_we", dma_we, 1'b0);
    checkOutput("rst_addr", dma_addr, 16'h0000);
    checkOutput("rst_dout", dma_dout, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    tick();
    wlog_addr.delete();
    wlog_data.delete();

    $display("[TB] PRG 01 04 AA BB CC");
    done_base = done_count;
    startDownload(8'h41);
    checkOutput("t1_busy", busy, 1'b1);
    applyStimulus(25'd0, 8'h01, 1'b0, 1'b0);
    applyStimulus(25'd1, 8'h04, 1'b0, 1'b0);
    applyStimulus(25'd2, 8'hAA, 1'b1, 1'b1);
    applyStimulus(25'd3, 8'hBB, 1'b1, 1'b1);
    applyStimulus(25'd4, 8'hCC, 1'b1, 1'b1);
    endDownload();
    expectWrite(16'h0401, 8'hAA);
    expectWrite(16'h0402, 8'hBB);
    expectWrite(16'h0403, 8'hCC);
    expectPointers(16'h0404);
    checkLog("t1");
    checkOutput("t1_done", 32'(done_count - done_base), 32'd1);
    checkOutput("t1_ovf", overflow, 1'b0);
    checkOutput("t1_idle", busy, 1'b0);

    $display("[TB] PRG at 7FFE with overflow");
    done_base = done_count;
    startDownload(8'h41);
    applyStimulus(25'd0, 8'hFE, 1'b0, 1'b0);
    applyStimulus(25'd1, 8'h7F, 1'b0, 1'b0);
    applyStimulus(25'd2, 8'h11, 1'b1, 1'b0);
    applyStimulus(25'd3, 8'h22, 1'b1, 1'b0);
    applyStimulus(25'd4, 8'h33, 1'b0, 1'b0);
    applyStimulus(25'd5, 8'h44, 1'b0, 1'b0);
    checkOutput("t2_ovf_set", overflow, 1'b1);
    endDownload();
    expectWrite(16'h7FFE, 8'h11);
    expectWrite(16'h7FFF, 8'h22);
    expectPointers(16'h8000);
    checkLog("t2");
    checkOutput("t2_done", 32'(done_count - done_base), 32'd1);
    checkOutput("t2_ovf_sticky", overflow, 1'b1);

    $display("[TB] ROM image window");
    done_base = done_count;
    startDownload(8'h00);
    checkOutput("t3_busy", busy, 1'b1);
    applyStimulus(25'h03FF, 8'h12, 1'b0, 1'b0);
    applyStimulus(25'h0400, 8'h5A, 1'b1, 1'b0);
    applyStimulus(25'h7FFF, 8'hA5, 1'b1, 1'b0);
    applyStimulus(25'h8000, 8'h77, 1'b0, 1'b0);
    endDownload();
    expectWrite(16'h8400, 8'h5A);
    expectWrite(16'hFFFF, 8'hA5);
    checkLog("t3");
    checkOutput("t3_done", 32'(done_count - done_base), 32'd1);

    $display("[TB] one-byte PRG");
    done_base = done_count;
    startDownload(8'h41);
    checkOutput("t4_ovf_clr", overflow, 1'b0);
    applyStimulus(25'd0, 8'h01, 1'b0, 1'b0);
    endDownload();
    checkLog("t4");
    checkOutput("t4_done", 32'(done_count - done_base), 32'd1);
    checkOutput("t4_idle", busy, 1'b0);

    $display("[TB] other index ignored");
    startDownload(8'h07);
    checkOutput("t4b_busy", busy, 1'b0);
    ioctl_download = 1'b0;
    tick();

    $display("[TB] reset during PATCH");
    done_base = done_count;
    startDownload(8'h41);
    applyStimulus(25'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(25'd1, 8'h10, 1'b0, 1'b0);
    applyStimulus(25'd2, 8'h99, 1'b1, 1'b0);
    ioctl_download = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 100 && seen < 2; i++) begin
        tick();
        if (dma_we === 1'b1)
          seen++;
      end
      checkOutput("t5_patch_seen", 32'(seen), 32'd2);
    end
    reset = 1'b1;
    tick();
    checkOutput("t5_wait", ioctl_wait, 1'b0);
    checkOutput("t5_we", dma_we, 1'b0);
    checkOutput("t5_addr", dma_addr, 16'h0000);
    checkOutput("t5_dout", dma_dout, 8'h00);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_ovf", overflow, 1'b0);
    reset = 1'b0;
    repeat (40) tick();
    expectWrite(16'h1000, 8'h99);
    expectWrite(16'h002A, 8'h01);
    expectWrite(16'h002B, 8'h10);
    checkLog("t5");
    checkOutput("t5_nodone", 32'(done_count - done_base), 32'd0);

    $display("[TB] restart while in DATA");
    done_base = done_count;
    startDownload(8'h41);
    applyStimulus(25'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(25'd1, 8'h20, 1'b0, 1'b0);
    applyStimulus(25'd2, 8'h11, 1'b1, 1'b0);
    ioctl_download = 1'b0;
    tick();
    startDownload(8'h41);
    checkOutput("t6_busy", busy, 1'b1);
    applyStimulus(25'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(25'd1, 8'h30, 1'b0, 1'b0);
    applyStimulus(25'd2, 8'h55, 1'b1, 1'b0);
    endDownload();
    expectWrite(16'h2000, 8'h11);
    expectWrite(16'h3000, 8'h55);
    expectPointers(16'h3001);
    checkLog("t6");
    checkOutput("t6_done", 32'(done_count - done_base), 32'd1);

`ifdef PET_LOADER_AUTORUN_EN
    $display("[TB] autorun enabled");
    done_base = done_count;
    autorun = 1'b1;
    startDownload(8'h41);
    autorun = 1'b0;
    applyStimulus(25'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(25'd1, 8'h04, 1'b0, 1'b0);
    applyStimulus(25'd2, 8'h42, 1'b1, 1'b0);
    endDownload();
    expectWrite(16'h0400, 8'h42);
    expectPointers(16'h0401);
    expectWrite(16'h026F, 8'h52);
    expectWrite(16'h0270, 8'h55);
    expectWrite(16'h0271, 8'h4E);
    expectWrite(16'h0272, 8'h0D);
    expectWrite(16'h009E, 8'h04);
    checkLog("t7");
    checkOutput("t7_done", 32'(done_count - done_base), 32'd1);

    $display("[TB] autorun disabled");
    done_base = done_count;
    startDownload(8'h41);
    applyStimulus(25'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(25'd1, 8'h04, 1'b0, 1'b0);
    applyStimulus(25'd2, 8'h42, 1'b1, 1'b0);
    endDownload();
    expectWrite(16'h0400, 8'h42);
    expectPointers(16'h0401);
    checkLog("t8");
    checkOutput("t8_done", 32'(done_count - done_base), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
